// File: rtl/axis_common_pkg.sv
// -----------------------------------------------------------------------------
// axis_common_pkg
// Shared definitions for the AXI4-Stream sample blocks.
//   - pk_state_e : packetizer FSM encoding (IDLE=0, RUN=1, STOPPING=2)
//   - Beat layout stored in stream FIFOs: {last, data}, last is the MSB.
// -----------------------------------------------------------------------------
package axis_common_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } pk_state_e;

    // Width of a stored beat for a given data width: data plus the last flag.
    function automatic int beat_width(input int data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// -----------------------------------------------------------------------------
// axis_sync_fifo
// Single-clock FIFO with storage held in a memory array only.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset (pointers only)
//   wr_en, wr_data   : write request and data (ignored when full without read)
//   rd_en, rd_data   : read request; rd_data shows the head entry
//   full, empty      : occupancy flags
//   level            : number of stored entries (0 .. 2^DEPTH_LOG2)
// -----------------------------------------------------------------------------
module axis_sync_fifo #(
    parameter int WIDTH      = 17,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0] PTR_ZERO  = {(DEPTH_LOG2+1){1'b0}};
    localparam logic [DEPTH_LOG2:0] LVL_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
    logic                  wr_go_s, rd_go_s;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level   = wr_ptr_q - rd_ptr_q;
    assign full    = (level == LVL_FULL);
    assign empty   = (level == PTR_ZERO);
    assign rd_data = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    // Qualify requests and advance pointers; a write into a full FIFO is legal only alongside a read.
    always_comb begin
        rd_go_s  = rd_en && !empty;
        wr_go_s  = wr_en && (!full || rd_go_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_go_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_go_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (wr_go_s) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/axis_frame_packetizer.sv
// -----------------------------------------------------------------------------
// axis_frame_packetizer
// Captures an un-throttled sample strobe into a FIFO and emits AXIS frames of
// a programmable length, tlast on the final sample of each frame.
// Ports:
//   aclk, resetn           : clock, asynchronous active-low reset
//   sample_data/valid      : free-running sample source (no backpressure)
//   enable                 : packetize request; frames are never truncated
//   frame_length           : samples per frame, latched at each frame start
//   overflow_clear         : clears the sticky overflow flag (set wins)
//   m_axis_tdata/tvalid/tlast/tready : AXIS master
//   overflow               : at least one sample dropped
//   fifo_level             : entries in FIFO memory (output register excluded)
// -----------------------------------------------------------------------------
module axis_frame_packetizer
    import axis_common_pkg::*;
#(
    parameter int inout_width        = 16,
    parameter int fifo_depth_log2    = 4,
    parameter int frame_length_width = 16
) (
    input  logic                          aclk,
    input  logic                          resetn,
    input  logic [inout_width-1:0]        sample_data,
    input  logic                          sample_valid,
    input  logic                          enable,
    input  logic [frame_length_width-1:0] frame_length,
    input  logic                          overflow_clear,
    output logic [inout_width-1:0]        m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic                          overflow,
    output logic [fifo_depth_log2:0]      fifo_level
);

    localparam int BEAT_W = beat_width(inout_width);
    localparam logic [frame_length_width-1:0] LEN_ZERO = {frame_length_width{1'b0}};
    localparam logic [frame_length_width-1:0] LEN_ONE  = {{(frame_length_width-1){1'b0}}, 1'b1};

    pk_state_e                     state_q, state_d;
    logic [frame_length_width-1:0] cnt_q, cnt_d;
    logic [frame_length_width-1:0] len_q, len_d;
    logic                          overflow_q, overflow_d;
    logic [inout_width-1:0]        tdata_q, tdata_d;
    logic                          tlast_q, tlast_d;
    logic                          tvalid_q, tvalid_d;

    logic                          fifo_full_s, fifo_empty_s;
    logic                          fifo_wr_s, fifo_rd_s;
    logic                          active_s, space_s, drop_s, last_s;
    logic [BEAT_W-1:0]             wr_beat_s, rd_beat_s;

    axis_sync_fifo #(
        .WIDTH      (BEAT_W),
        .DEPTH_LOG2 (fifo_depth_log2)
    ) u_fifo (
        .clk     (aclk),
        .rst_n   (resetn),
        .wr_en   (fifo_wr_s),
        .wr_data (wr_beat_s),
        .rd_en   (fifo_rd_s),
        .rd_data (rd_beat_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (fifo_level)
    );

    // Write/read qualification: the output register pulls from memory whenever it is free or being drained.
    always_comb begin
        active_s  = (state_q != ST_IDLE);
        fifo_rd_s = !fifo_empty_s && (!tvalid_q || m_axis_tready);
        space_s   = !fifo_full_s || fifo_rd_s;
        fifo_wr_s = active_s && sample_valid && space_s;
        drop_s    = active_s && sample_valid && !space_s;
        // Lengths 0 and 1 both mean a one-sample frame.
        if (len_q <= LEN_ONE) begin
            last_s = 1'b1;
        end else begin
            last_s = (cnt_q == (len_q - LEN_ONE));
        end
        wr_beat_s = {last_s, sample_data};
    end

    // Frame counter and FSM; leaving RUN looks at the post-write count so a frame just started is finished.
    always_comb begin
        cnt_d   = cnt_q;
        len_d   = len_q;
        state_d = state_q;
        if (fifo_wr_s) begin
            if (last_s) begin
                cnt_d = LEN_ZERO;
                len_d = frame_length;
            end else begin
                cnt_d = cnt_q + LEN_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                    cnt_d   = LEN_ZERO;
                    len_d   = frame_length;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = (cnt_d == LEN_ZERO) ? ST_IDLE : ST_STOPPING;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STOPPING: begin
                if (fifo_wr_s && last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOPPING;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky overflow and output register.
    always_comb begin
        overflow_d = overflow_q;
        tdata_d    = tdata_q;
        tlast_d    = tlast_q;
        tvalid_d   = tvalid_q;
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (overflow_clear) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (fifo_rd_s) begin
            tdata_d  = rd_beat_s[inout_width-1:0];
            tlast_d  = rd_beat_s[BEAT_W-1];
            tvalid_d = 1'b1;
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
        end
    end

    // State registers.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= LEN_ZERO;
            len_q      <= LEN_ZERO;
            overflow_q <= 1'b0;
            tdata_q    <= {inout_width{1'b0}};
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            overflow_q <= overflow_d;
            tdata_q    <= tdata_d;
            tlast_q    <= tlast_d;
            tvalid_q   <= tvalid_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_axis_frame_packetizer.sv
module tb_axis_frame_packetizer;

    localparam int DW    = 16;
    localparam int DL2   = 2;
    localparam int FLW   = 16;
    localparam int DEPTH = 1 << DL2;

    logic            aclk = 1'b0;
    logic            resetn = 1'b0;
    logic [DW-1:0]   sample_data = '0;
    logic            sample_valid = 1'b0;
    logic            enable = 1'b0;
    logic [FLW-1:0]  frame_length = '0;
    logic            overflow_clear = 1'b0;
    logic [DW-1:0]   m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tlast;
    logic            m_axis_tready = 1'b0;
    logic            overflow;
    logic [DL2:0]    fifo_level;

    always #5 aclk = ~aclk;

    axis_frame_packetizer #(
        .inout_width        (DW),
        .fifo_depth_log2    (DL2),
        .frame_length_width (FLW)
    ) dut (
        .aclk           (aclk),
        .resetn         (resetn),
        .sample_data    (sample_data),
        .sample_valid   (sample_valid),
        .enable         (enable),
        .frame_length   (frame_length),
        .overflow_clear (overflow_clear),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .overflow       (overflow),
        .fifo_level     (fifo_level)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model: a queue of buffered beats, one output slot, and frame position.
    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    beat_t m_mem[$];
    beat_t m_out;
    bit    m_outv;
    bit    m_busy;       // packetizing (not idle)
    bit    m_finishing;  // enable dropped, completing current frame
    int    m_pos;
    int    m_len;
    bit    m_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mem.delete();
        m_out       = '0;
        m_outv      = 1'b0;
        m_busy      = 1'b0;
        m_finishing = 1'b0;
        m_pos       = 0;
        m_len       = 0;
        m_ovf       = 1'b0;
    endtask

    task automatic model_clock();
        bit rd, room, wr, drop, lst;
        rd   = (m_mem.size() > 0) && (!m_outv || m_axis_tready);
        room = (m_mem.size() < DEPTH) || rd;
        wr   = m_busy && sample_valid && room;
        drop = m_busy && sample_valid && !room;
        lst  = (m_len <= 1) || (m_pos == m_len - 1);
        if (rd) begin
            m_out  = m_mem.pop_front();
            m_outv = 1'b1;
        end else if (m_outv && m_axis_tready) begin
            m_outv = 1'b0;
        end
        if (wr) begin
            m_mem.push_back({lst, sample_data});
            if (lst) begin
                m_pos = 0;
                m_len = int'(frame_length);
            end else begin
                m_pos++;
            end
        end
        if (!m_busy) begin
            if (enable) begin
                m_busy = 1'b1;
                m_finishing = 1'b0;
                m_pos = 0;
                m_len = int'(frame_length);
            end
        end else if (!m_finishing) begin
            if (!enable) begin
                if (m_pos == 0) m_busy = 1'b0;
                else m_finishing = 1'b1;
            end
        end else if (wr && lst) begin
            m_busy = 1'b0;
            m_finishing = 1'b0;
        end
        if (drop) m_ovf = 1'b1;
        else if (overflow_clear) m_ovf = 1'b0;
    endtask

    task automatic compare_all();
        check("tvalid", m_axis_tvalid, m_outv);
        if (m_outv) begin
            check("tdata", m_axis_tdata, m_out.data);
            check("tlast", m_axis_tlast, m_out.last);
        end
        check("overflow", overflow, m_ovf);
        check("fifo_level", fifo_level, m_mem.size());
    endtask

    task automatic cycle();
        @(posedge aclk);
        model_clock();
        #1;
        compare_all();
    endtask

    task automatic strobe(input logic [DW-1:0] d);
        sample_data  = d;
        sample_valid = 1'b1;
        cycle();
        sample_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        model_reset();
        #1;
        check("reset_tvalid", m_axis_tvalid, 1'b0);
        check("reset_tlast", m_axis_tlast, 1'b0);
        check("reset_tdata", m_axis_tdata, 16'h0);
        check("reset_overflow", overflow, 1'b0);
        check("reset_level", fifo_level, 3'd0);
        @(negedge aclk);
        @(negedge aclk);
        resetn = 1'b1;

        // Phase A: 12 back-to-back samples, frames of 4.
        frame_length  = 16'd4;
        enable        = 1'b1;
        m_axis_tready = 1'b1;
        cycle();
        for (int i = 1; i <= 12; i++) strobe(DW'(i));
        idle_cycles(4);

        // Phase B: drop enable after sample 6; frame completes at 8, rest ignored.
        for (int i = 1; i <= 12; i++) begin
            if (i == 7) enable = 1'b0;
            strobe(DW'(16'h100 + i));
        end
        idle_cycles(4);

        // Phase C: backpressure and overflow.
        frame_length  = 16'd8;
        enable        = 1'b1;
        m_axis_tready = 1'b0;
        cycle();
        for (int i = 1; i <= 7; i++) strobe(DW'(16'h200 + i));
        check("bp_overflow", overflow, 1'b1);
        check("bp_level", fifo_level, 3'd4);
        check("bp_tvalid", m_axis_tvalid, 1'b1);
        overflow_clear = 1'b1;
        strobe(16'h0208);
        overflow_clear = 1'b0;
        check("coincident_set_clear", overflow, 1'b1);
        overflow_clear = 1'b1;
        cycle();
        overflow_clear = 1'b0;
        check("clear_alone", overflow, 1'b0);
        m_axis_tready = 1'b1;
        idle_cycles(3);
        for (int i = 9; i <= 14; i++) strobe(DW'(16'h200 + i));
        idle_cycles(4);

        // Phase D: single-sample frames, then re-latch 3 -> 2.
        enable = 1'b0;
        for (int i = 0; i < 10; i++) strobe(DW'(16'h300 + i));
        idle_cycles(4);
        check("stopped_idle_level", fifo_level, 3'd0);
        frame_length = 16'd1;
        enable       = 1'b1;
        cycle();
        for (int i = 0; i < 4; i++) strobe(DW'(16'h400 + i));
        frame_length = 16'd3;
        strobe(16'h0404);
        strobe(16'h0405);
        frame_length = 16'd2;
        strobe(16'h0406);
        strobe(16'h0407);
        strobe(16'h0408);
        strobe(16'h0409);
        idle_cycles(4);

        // Phase E: randomized traffic.
        for (int i = 0; i < 400; i++) begin
            sample_data    = DW'($urandom);
            sample_valid   = ($urandom_range(0, 3) != 0);
            m_axis_tready  = ($urandom_range(0, 2) != 0);
            overflow_clear = ($urandom_range(0, 15) == 0);
            frame_length   = FLW'($urandom_range(0, 5));
            if ($urandom_range(0, 30) == 0) enable = ~enable;
            cycle();
        end
        sample_valid   = 1'b0;
        overflow_clear = 1'b0;
        m_axis_tready  = 1'b1;
        idle_cycles(8);

        // Phase F: asynchronous reset mid-frame with tvalid high.
        enable        = 1'b1;
        frame_length  = 16'd4;
        m_axis_tready = 1'b0;
        cycle();
        for (int i = 1; i <= 7; i++) strobe(DW'(16'h500 + i));
        check("pre_reset_tvalid", m_axis_tvalid, 1'b1);
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        check("async_tvalid", m_axis_tvalid, 1'b0);
        check("async_tlast", m_axis_tlast, 1'b0);
        check("async_overflow", overflow, 1'b0);
        check("async_level", fifo_level, 3'd0);
        @(negedge aclk);
        resetn        = 1'b1;
        m_axis_tready = 1'b1;
        cycle();
        for (int i = 1; i <= 8; i++) strobe(DW'(16'h600 + i));
        idle_cycles(4);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
